// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared AES inverse-cipher definitions: round count, FSM states, GF(2^8) helpers,
// Rcon lookup and state byte indexing (byte 0 sits in bits 127:120).
package aes_inv_cipher_iter_pkg;

  localparam int AES_NR = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int byte_msb(input int n);
    return 127 - 8 * n;
  endfunction

  // Source byte for InvShiftRows: row r of column c comes from column (c - r) mod 4.
  function automatic int isr_src(input int n);
    int row;
    int col;
    row = n % 4;
    col = n / 4;
    return row + 4 * ((col - row + 4) % 4);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
            gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
            gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
            gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Load/result bus of the iterative AES inverse cipher.
interface aes_inv_cipher_iter_if;
  logic         ld;
  logic [127:0] key_in;
  logic [127:0] text_in;
  logic [127:0] text_out;
  logic         done;
  logic         busy;

  modport master (output ld, key_in, text_in, input text_out, done, busy);
  modport slave  (input ld, key_in, text_in, output text_out, done, busy);
endinterface

// File: rtl/aes_inv_sbox_lut.sv
// Inverse AES S-box, combinational 256-entry table with the same a/d ports as aes_sbox_lut.
module aes_inv_sbox_lut (
  input  logic [7:0] a,
  output logic [7:0] d
);
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign d = INV_SBOX[a];
endmodule

// File: rtl/aes_sbox_lut.sv
// Forward AES S-box, purely combinational 256-entry table.
module aes_sbox_lut (
  input  logic [7:0] a,
  output logic [7:0] d
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign d = SBOX[a];
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys regenerated
// backwards from the round-10 key while the block is being decrypted.
module aes_inv_cipher_iter
  import aes_inv_cipher_iter_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_cipher_iter_if.slave bus
);

  state_e       r_fsm, w_fsm_nxt;
  logic [127:0] r_state, r_rkey, r_text_out;
  logic [3:0]   r_rcnt;
  logic         r_done;
  logic         w_load, w_step, w_finish, w_busy;

  logic [127:0] w_isr, w_isb, w_ark, w_imc, w_rnd, w_kprev;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_k1p, w_k2p, w_k3p, w_rot, w_sub;

  // Reverse key schedule: k_{r-1} from k_r, using Rcon of the current round.
  assign {w_k0, w_k1, w_k2, w_k3} = r_rkey;
  assign w_k3p  = w_k3 ^ w_k2;
  assign w_k2p  = w_k2 ^ w_k1;
  assign w_k1p  = w_k1 ^ w_k0;
  assign w_rot  = {w_k3p[23:0], w_k3p[31:24]};
  assign w_kprev = {w_k0 ^ w_sub ^ {rcon(r_rcnt), 24'h000000}, w_k1p, w_k2p, w_k3p};

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox_lut u_sbox (
      .a (w_rot[31-8*g -: 8]),
      .d (w_sub[31-8*g -: 8])
    );
  end

  for (genvar n = 0; n < 16; n++) begin : g_bytes
    localparam int DST = byte_msb(n);
    localparam int SRC = byte_msb(isr_src(n));
    assign w_isr[DST -: 8] = r_state[SRC -: 8];
    aes_inv_sbox_lut u_inv_sbox (
      .a (w_isr[DST -: 8]),
      .d (w_isb[DST -: 8])
    );
  end

  assign w_ark = w_isb ^ w_kprev;

  for (genvar c = 0; c < 4; c++) begin : g_cols
    assign w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
  end

  // The last round skips InvMixColumns.
  assign w_rnd = (r_rcnt == 4'd1) ? w_ark : w_imc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    if (bus.ld)                                 w_fsm_nxt = ST_RUN;
    else if (r_fsm == ST_RUN && r_rcnt == 4'd1) w_fsm_nxt = ST_IDLE;
  end

  // A load always wins, so an in-flight block is silently dropped.
  always_comb begin
    w_load   = bus.ld;
    w_step   = 1'b0;
    w_finish = 1'b0;
    w_busy   = 1'b0;
    case (r_fsm)
      ST_RUN: begin
        w_busy   = 1'b1;
        w_step   = ~bus.ld;
        w_finish = ~bus.ld && (r_rcnt == 4'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= '0;
      r_rkey     <= '0;
      r_rcnt     <= '0;
      r_text_out <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_state <= bus.text_in ^ bus.key_in;
        r_rkey  <= bus.key_in;
        r_rcnt  <= 4'(NR);
      end else if (w_step) begin
        r_state <= w_rnd;
        r_rkey  <= w_kprev;
        r_rcnt  <= r_rcnt - 4'd1;
        if (w_finish) r_text_out <= w_ark;
      end
    end
  end

  assign bus.text_out = r_text_out;
  assign bus.done     = r_done;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter using FIPS-197 vectors plus an S-box round trip.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] K1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t mon_e;

  logic [7:0] sb_x, sb_mid, sb_back;

  aes_inv_cipher_iter_if bus ();

  aes_inv_cipher_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  aes_sbox_lut     u_fwd (.a(sb_x),   .d(sb_mid));
  aes_inv_sbox_lut u_inv (.a(sb_mid), .d(sb_back));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [127:0] k, input logic [127:0] c,
                       input logic [127:0] p, input bit expect_done);
    exp_t e;
    bus.ld      = 1'b1;
    bus.key_in  = k;
    bus.text_in = c;
    if (expect_done) begin
      e.pt  = p;
      e.due = cyc + 11;
      q.push_back(e);
    end
    @(negedge clk);
    bus.ld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 128'(bus.done), 128'd0);
      end else begin
        mon_e = q.pop_front();
        chk("text_out", bus.text_out, mon_e.pt);
        chk("done_cycle", 128'(cyc), 128'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst         = 1'b1;
    bus.ld      = 1'b0;
    bus.key_in  = '0;
    bus.text_in = '0;

    for (int i = 0; i < 256; i++) begin
      sb_x = i[7:0];
      #1;
      chk("sbox_roundtrip", 128'(sb_back), 128'(sb_x));
    end
    sb_x = 8'h00; #1;
    chk("sbox_00", 128'(sb_mid), 128'h63);
    chk("inv_63", 128'(sb_back), 128'h00);
    sb_x = 8'hff; #1;
    chk("sbox_ff", 128'(sb_mid), 128'h16);
    chk("inv_16", 128'(sb_back), 128'hff);

    repeat (2) @(negedge clk);
    chk("reset_text_out", bus.text_out, 128'd0);
    chk("reset_done", 128'(bus.done), 128'd0);
    chk("reset_busy", 128'(bus.busy), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 with busy profile
    issue(K1, C1, P1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("busy_run", 128'(bus.busy), 128'd1);
      @(negedge clk);
    end
    chk("busy_after", 128'(bus.busy), 128'd0);
    @(negedge clk);
    chk("done_pulse_width", 128'(bus.done), 128'd0);
    chk("c1_hold", bus.text_out, P1);

    // FIPS-197 B
    issue(K2, C2, P2, 1'b1);
    repeat (12) @(negedge clk);

    // Back-to-back: next load on the done cycle
    issue(K1, C1, P1, 1'b1);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 128'(bus.done), 128'd1);
    issue(K2, C2, P2, 1'b1);
    repeat (4) @(negedge clk);
    chk("b2b_hold", bus.text_out, P1);
    repeat (10) @(negedge clk);

    // Abort: reload mid-run, first block produces nothing
    issue(K1, C1, P1, 1'b0);
    repeat (3) @(negedge clk);
    issue(K2, C2, P2, 1'b1);
    repeat (12) @(negedge clk);

    // Load coinciding with the final round
    issue(K1, C1, P1, 1'b0);
    repeat (9) @(negedge clk);
    issue(K2, C2, P2, 1'b1);
    chk("final_ld_no_done", 128'(bus.done), 128'd0);
    chk("final_ld_text_kept", bus.text_out, P2);
    repeat (12) @(negedge clk);

    // Reset mid-operation
    issue(K1, C1, P1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_text_out", bus.text_out, 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(K1, C1, P1, 1'b1);
    repeat (12) @(negedge clk);

    chk("queue_drained", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
